// File: rtl/match_priority_resolver_pkg.sv
// Package match_priority_pkg: shared types and the candidate compare rule for
// the match/priority resolver.
//   RULE_ID_W   width of one rule ID (lower value = higher priority)
//   CANDS       candidates per lane
//   LANES       number of input lanes
//   SRC_W       width of {lane, slot} source tag
//   cand_t      {hit, id, src} candidate record carried through the reduction tree
//   cand_better returns 1 when candidate a should win over candidate b
package match_priority_pkg;

   localparam int RULE_ID_W = 14;
   localparam int CANDS     = 8;
   localparam int LANES     = 2;
   localparam int SRC_W     = 4;

   typedef struct packed {
      logic                 hit;
      logic [RULE_ID_W-1:0] id;
      logic [SRC_W-1:0]     src;
   } cand_t;

   // Unmatched candidates carry id=0/src=0, so a pair of misses resolves to
   // an all-zero record no matter which side is picked.
   // src = {lane, slot}, so comparing src on equal IDs gives both the
   // lower-slot and the lane1-first tie rules.
   function automatic logic cand_better(input cand_t a, input cand_t b);
      if (a.hit != b.hit) return a.hit;
      if (a.id != b.id) return a.id < b.id;
      return a.src <= b.src;
   endfunction

endpackage

// File: rtl/match_priority_resolver_if.sv
// Interface match_priority_resolver_if: two-lane match/priority bus in, resolved
// result handshake out.
//   rule_pri_in1/2   CANDS packed rule IDs per lane (slot k = bits [k*RULE_ID +: RULE_ID])
//   match_flag_in1/2 per-slot match flags
//   data_valid_in1/2 lane qualifiers
//   res_rule_id, res_hit, res_src, res_valid  FIFO head toward the action stage
//   res_ready        downstream accept
//   fifo_afull       result FIFO almost full
//   drop_pulse       one-cycle pulse when a result was lost to a full FIFO
// modport master: upstream/downstream environment; modport slave: the resolver.
interface match_priority_resolver_if
   import match_priority_pkg::*;
#(
   parameter int RULE_ID = RULE_ID_W,
   parameter int NCANDS  = CANDS
);

   logic [NCANDS*RULE_ID-1:0] rule_pri_in1;
   logic [NCANDS-1:0]         match_flag_in1;
   logic                      data_valid_in1;
   logic [NCANDS*RULE_ID-1:0] rule_pri_in2;
   logic [NCANDS-1:0]         match_flag_in2;
   logic                      data_valid_in2;
   logic [RULE_ID-1:0]        res_rule_id;
   logic                      res_hit;
   logic [SRC_W-1:0]          res_src;
   logic                      res_valid;
   logic                      res_ready;
   logic                      fifo_afull;
   logic                      drop_pulse;

   modport master (
      output rule_pri_in1, match_flag_in1, data_valid_in1,
      output rule_pri_in2, match_flag_in2, data_valid_in2,
      output res_ready,
      input  res_rule_id, res_hit, res_src, res_valid, fifo_afull, drop_pulse
   );

   modport slave (
      input  rule_pri_in1, match_flag_in1, data_valid_in1,
      input  rule_pri_in2, match_flag_in2, data_valid_in2,
      input  res_ready,
      output res_rule_id, res_hit, res_src, res_valid, fifo_afull, drop_pulse
   );

endinterface

// File: rtl/match_priority_resolver_cmp2.sv
// Module pri_cmp2: registered 2->1 candidate compare cell.
//   clk, rst  clock and asynchronous active-high reset (valid only)
//   a, b      candidates; a is always the lower {lane, slot} side
//   vld_in    stage valid in
//   y         registered winner
//   vld_out   registered stage valid
module pri_cmp2
   import match_priority_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  cand_t a,
   input  cand_t b,
   input  logic  vld_in,
   output cand_t y,
   output logic  vld_out
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_out <= 1'b0;
      else     vld_out <= vld_in;
   end

   always_ff @(posedge clk) begin
      y <= cand_better(a, b) ? a : b;
   end

endmodule

// File: rtl/match_priority_resolver.sv
// Module match_priority_resolver: reduces 2 lanes x 8 candidates to the
// lowest matched rule ID and queues each result in a first-word-fall-through
// FIFO toward the action stage.
//   clk          rising-edge clock
//   RST          asynchronous active-high reset
//   bus          match_priority_resolver_if.slave (lane inputs, result handshake)
//   stat_*_cnt   32-bit saturating hit/miss/drop counters, present only when
//                MATCH_PRIORITY_STATS_EN is defined
// Latency: inputs sampled on edge 1 appear at the FIFO head after edge 5
// (S1..S4 compare registers, then the FIFO write).
module match_priority_resolver
   import match_priority_pkg::*;
#(
   parameter int RULE_ID    = RULE_ID_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic RST,
   match_priority_resolver_if.slave bus
`ifdef MATCH_PRIORITY_STATS_EN
   ,
   output logic [31:0] stat_hit_cnt,
   output logic [31:0] stat_miss_cnt,
   output logic [31:0] stat_drop_cnt
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   cand_t leaf [LANES][CANDS];
   logic  vld_p0;

   // Leaves: a slot only matches when its lane is qualified; misses are zeroed.
   always_comb begin
      for (int k = 0; k < CANDS; k++) begin
         leaf[0][k] = '0;
         leaf[1][k] = '0;
         if (bus.data_valid_in1 && bus.match_flag_in1[k]) begin
            leaf[0][k].hit = 1'b1;
            leaf[0][k].id  = bus.rule_pri_in1[k*RULE_ID +: RULE_ID];
            leaf[0][k].src = SRC_W'(k);
         end
         if (bus.data_valid_in2 && bus.match_flag_in2[k]) begin
            leaf[1][k].hit = 1'b1;
            leaf[1][k].id  = bus.rule_pri_in2[k*RULE_ID +: RULE_ID];
            leaf[1][k].src = SRC_W'(CANDS + k);
         end
      end
   end

   assign vld_p0 = bus.data_valid_in1 | bus.data_valid_in2;

   cand_t c_p1 [LANES][CANDS/2];
   cand_t c_p2 [LANES][CANDS/4];
   cand_t c_p3 [LANES];
   cand_t c_p4;
   logic [LANES-1:0][CANDS/2-1:0] vc_p1;
   logic [LANES-1:0][CANDS/4-1:0] vc_p2;
   logic [LANES-1:0]              vc_p3;
   logic vld_p1, vld_p2, vld_p3, vld_p4;

   // Every cell of a stage sees the same valid, so the AND is just that valid.
   assign vld_p1 = &vc_p1;
   assign vld_p2 = &vc_p2;
   assign vld_p3 = &vc_p3;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      // S1: 8 -> 4
      for (genvar j = 0; j < CANDS/2; j++) begin : g_s1
         pri_cmp2 u_cmp (.clk(clk), .rst(RST), .a(leaf[l][2*j]), .b(leaf[l][2*j+1]),
                         .vld_in(vld_p0), .y(c_p1[l][j]), .vld_out(vc_p1[l][j]));
      end
      // S2: 4 -> 2
      for (genvar j = 0; j < CANDS/4; j++) begin : g_s2
         pri_cmp2 u_cmp (.clk(clk), .rst(RST), .a(c_p1[l][2*j]), .b(c_p1[l][2*j+1]),
                         .vld_in(vld_p1), .y(c_p2[l][j]), .vld_out(vc_p2[l][j]));
      end
      // S3: 2 -> 1
      pri_cmp2 u_s3 (.clk(clk), .rst(RST), .a(c_p2[l][0]), .b(c_p2[l][1]),
                     .vld_in(vld_p2), .y(c_p3[l]), .vld_out(vc_p3[l]));
   end

   // S4: lane merge, lane1 on the a side so it wins ties
   pri_cmp2 u_s4 (.clk(clk), .rst(RST), .a(c_p3[0]), .b(c_p3[1]),
                  .vld_in(vld_p3), .y(c_p4), .vld_out(vld_p4));

   // Result FIFO (first-word-fall-through)
   cand_t            mem [FIFO_DEPTH];
   cand_t            head;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full, pop, push_ok, drop, drop_r;

   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign pop     = bus.res_valid & bus.res_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok = vld_p4 & (~full | pop);
   assign drop    = vld_p4 & full & ~pop;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         drop_r <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         count  <= count + CNT_W'(push_ok) - CNT_W'(pop);
         drop_r <= drop;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= c_p4;
   end

   assign head            = mem[rd_ptr];
   assign bus.res_valid   = (count != '0);
   // Gate with valid so reset and empty always present an all-zero result.
   assign bus.res_hit     = bus.res_valid & head.hit;
   assign bus.res_rule_id = bus.res_valid ? head.id  : '0;
   assign bus.res_src     = bus.res_valid ? head.src : '0;
   assign bus.fifo_afull  = (count >= CNT_W'(FIFO_DEPTH - 1));
   assign bus.drop_pulse  = drop_r;

`ifdef MATCH_PRIORITY_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         stat_hit_cnt  <= '0;
         stat_miss_cnt <= '0;
         stat_drop_cnt <= '0;
      end else begin
         if (push_ok &&  c_p4.hit) stat_hit_cnt  <= sat_inc(stat_hit_cnt);
         if (push_ok && !c_p4.hit) stat_miss_cnt <= sat_inc(stat_miss_cnt);
         if (drop)                 stat_drop_cnt <= sat_inc(stat_drop_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_match_priority_resolver.sv
// Testbench for match_priority_resolver: directed scenarios plus randomized
// traffic against a queue-based reference model (linear-scan winner search,
// fixed-latency delivery queue, bounded result queue).
module tb_match_priority_resolver;
   import match_priority_pkg::*;

   localparam int RID   = RULE_ID_W;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic           hit;
      logic [RID-1:0] id;
      logic [3:0]     src;
   } res_t;

   typedef struct packed {
      logic                v1;
      logic                v2;
      logic [7:0]          f1;
      logic [7:0]          f2;
      logic [7:0][RID-1:0] ids1;
      logic [7:0][RID-1:0] ids2;
   } ev_t;

   typedef struct packed {
      logic ev;
      res_t r;
   } pipe_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   match_priority_resolver_if #(.RULE_ID(RID), .NCANDS(8)) bus ();

`ifdef MATCH_PRIORITY_STATS_EN
   logic [31:0] stat_hit_cnt, stat_miss_cnt, stat_drop_cnt;
   match_priority_resolver #(.RULE_ID(RID), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .RST(rst), .bus(bus),
      .stat_hit_cnt(stat_hit_cnt), .stat_miss_cnt(stat_miss_cnt), .stat_drop_cnt(stat_drop_cnt));
`else
   match_priority_resolver #(.RULE_ID(RID), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .RST(rst), .bus(bus));
`endif

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   ev_t   cur_ev;
   pipe_t pipe_q[$];
   res_t  fifo_q[$];
   logic  exp_drop = 1'b0;
   int    m_hit = 0, m_miss = 0, m_drop = 0;

   // Winner = lowest ID among qualified matches; scan order lane1 then lane2,
   // ascending slot, keep first on equal IDs.
   function automatic res_t ref_winner(input ev_t e);
      res_t r = '0;
      for (int lane = 0; lane < 2; lane++) begin
         for (int s = 0; s < 8; s++) begin
            logic           q  = lane == 0 ? e.v1 : e.v2;
            logic           f  = lane == 0 ? e.f1[s] : e.f2[s];
            logic [RID-1:0] id = lane == 0 ? e.ids1[s] : e.ids2[s];
            if (q && f && (!r.hit || id < r.id)) begin
               r.hit = 1'b1;
               r.id  = id;
               r.src = 4'(lane * 8 + s);
            end
         end
      end
      return r;
   endfunction

   function automatic ev_t rand_ev(input int pct_valid, input bit narrow);
      ev_t e;
      e.v1 = ($urandom_range(0, 99) < pct_valid);
      e.v2 = ($urandom_range(0, 99) < pct_valid);
      e.f1 = 8'($urandom);
      e.f2 = 8'($urandom);
      for (int s = 0; s < 8; s++) begin
         e.ids1[s] = narrow ? RID'($urandom_range(0, 15)) : RID'($urandom);
         e.ids2[s] = narrow ? RID'($urandom_range(0, 15)) : RID'($urandom);
      end
      return e;
   endfunction

   task automatic drive(input ev_t e);
      cur_ev             = e;
      bus.data_valid_in1 = e.v1;
      bus.data_valid_in2 = e.v2;
      bus.match_flag_in1 = e.f1;
      bus.match_flag_in2 = e.f2;
      bus.rule_pri_in1   = e.ids1;
      bus.rule_pri_in2   = e.ids2;
   endtask

   task automatic clear_model();
      pipe_q.delete();
      fifo_q.delete();
      exp_drop = 1'b0;
      m_hit = 0; m_miss = 0; m_drop = 0;
   endtask

   // One clock edge: advance the reference model, then settle 1 time unit.
   task automatic tick();
      pipe_t cur, item;
      logic  pop, have;
      res_t  gone;
      @(posedge clk);
      cur.ev = cur_ev.v1 | cur_ev.v2;
      cur.r  = ref_winner(cur_ev);
      pop    = (fifo_q.size() > 0) && bus.res_ready;
      pipe_q.push_back(cur);
      have = 1'b0;
      item = '0;
      if (pipe_q.size() > 4) begin
         item = pipe_q.pop_front();
         have = item.ev;
      end
      exp_drop = 1'b0;
      if (pop) gone = fifo_q.pop_front();
      if (have) begin
         if (fifo_q.size() < DEPTH) begin
            fifo_q.push_back(item.r);
            if (item.r.hit) m_hit++; else m_miss++;
         end else begin
            exp_drop = 1'b1;
            m_drop++;
         end
      end
      #1;
   endtask

   function automatic logic [21:0] dut_out();
      return {bus.res_valid, bus.res_hit, bus.res_rule_id, bus.res_src, bus.fifo_afull, bus.drop_pulse};
   endfunction

   function automatic logic [21:0] model_out();
      res_t h = '0;
      if (fifo_q.size() > 0) h = fifo_q[0];
      return {fifo_q.size() > 0, h.hit, h.id, h.src, fifo_q.size() >= DEPTH - 1, exp_drop};
   endfunction

   task automatic test_reset();
      drive('0);
      bus.res_ready = 1'b1;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (dut_out() !== 22'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=%h", dut_out(), 22'd0);
      end
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      clear_model();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (dut_out() !== model_out()) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=%h", dut_out(), model_out());
         end
      end
   endtask

   task automatic test_basic();
      ev_t e = rand_ev(100, 0);
      e.v1 = 1'b1; e.v2 = 1'b0; e.f1 = 8'h24;
      e.ids1[2] = RID'(100); e.ids1[5] = RID'(37);
      bus.res_ready = 1'b1;
      drive(e);
      tick();
      drive('0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid got=%b exp=0", bus.res_valid);
         end
      end
      tick();
      checks++;
      if (dut_out() >> 2 !== {1'b1, 1'b1, RID'(37), 4'h5}) begin
         failures++;
         $display("FAIL basic_result got=%h exp=%h", dut_out() >> 2, {1'b1, 1'b1, RID'(37), 4'h5});
      end
      checks++;
      if (dut_out() !== model_out()) begin
         failures++;
         $display("FAIL basic_model got=%h exp=%h", dut_out(), model_out());
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_tie();
      ev_t a = rand_ev(100, 0);
      ev_t b;
      a.v1 = 1'b1; a.v2 = 1'b1; a.f1 = 8'h01; a.f2 = 8'h08;
      a.ids1[0] = RID'(9); a.ids2[3] = RID'(9);
      b = a;
      b.ids2[3] = RID'(8);
      bus.res_ready = 1'b1;
      drive(a); tick();
      drive(b); tick();
      drive('0);
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (dut_out() >> 2 !== {1'b1, 1'b1, RID'(9), 4'h0}) begin
         failures++;
         $display("FAIL tie_lane1 got=%h exp=%h", dut_out() >> 2, {1'b1, 1'b1, RID'(9), 4'h0});
      end
      tick();
      checks++;
      if (dut_out() >> 2 !== {1'b1, 1'b1, RID'(8), 4'hB}) begin
         failures++;
         $display("FAIL tie_lane2_lower got=%h exp=%h", dut_out() >> 2, {1'b1, 1'b1, RID'(8), 4'hB});
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_miss();
      ev_t c = rand_ev(100, 0);
      ev_t d = rand_ev(100, 0);
      c.v1 = 1'b1; c.v2 = 1'b1; c.f1 = 8'h00; c.f2 = 8'h00;
      d.v1 = 1'b0; d.v2 = 1'b0; d.f1 = 8'hFF; d.f2 = 8'hFF;
      bus.res_ready = 1'b1;
      drive(c); tick();
      drive(d); tick();
      drive('0);
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (dut_out() >> 2 !== {1'b1, 1'b0, RID'(0), 4'h0}) begin
         failures++;
         $display("FAIL miss_result got=%h exp=%h", dut_out() >> 2, {1'b1, 1'b0, RID'(0), 4'h0});
      end
      tick();
      checks++;
      if (bus.res_valid !== 1'b0) begin
         failures++;
         $display("FAIL miss_no_write got=%b exp=0", bus.res_valid);
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_full_drop();
      int drops = 0;
      bus.res_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         ev_t e = rand_ev(100, 1);
         e.v1 = 1'b1; e.f1[i] = 1'b1;
         drive(e);
         tick();
         checks++;
         if (dut_out() !== model_out()) begin
            failures++;
            $display("FAIL full_fill got=%h exp=%h", dut_out(), model_out());
         end
      end
      drive('0);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.drop_pulse === 1'b1) drops++;
         checks++;
         if (dut_out() !== model_out()) begin
            failures++;
            $display("FAIL full_hold got=%h exp=%h", dut_out(), model_out());
         end
      end
      checks++;
      if (drops !== 2) begin
         failures++;
         $display("FAIL full_drop_count got=%0d exp=2", drops);
      end
      checks++;
      if (bus.fifo_afull !== 1'b1) begin
         failures++;
         $display("FAIL full_afull got=%b exp=1", bus.fifo_afull);
      end
`ifdef MATCH_PRIORITY_STATS_EN
      checks++;
      if ({stat_hit_cnt, stat_miss_cnt, stat_drop_cnt} !== {32'(m_hit), 32'(m_miss), 32'(m_drop)}) begin
         failures++;
         $display("FAIL stats got=%0d/%0d/%0d exp=%0d/%0d/%0d", stat_hit_cnt, stat_miss_cnt, stat_drop_cnt, m_hit, m_miss, m_drop);
      end
`endif
      bus.res_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (dut_out() !== model_out()) begin
            failures++;
            $display("FAIL full_drain got=%h exp=%h", dut_out(), model_out());
         end
      end
   endtask

   task automatic test_full_pop_push();
      bus.res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ev_t e = rand_ev(100, 0);
         e.v2 = 1'b1; e.f2[7 - i] = 1'b1;
         drive(e);
         tick();
      end
      drive('0);
      for (int i = 0; i < 3; i++) tick();
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      checks++;
      if (bus.drop_pulse !== 1'b0 || bus.fifo_afull !== 1'b1 || bus.res_valid !== 1'b1) begin
         failures++;
         $display("FAIL fullpp_state got=%b%b%b exp=011", bus.drop_pulse, bus.fifo_afull, bus.res_valid);
      end
      checks++;
      if (dut_out() !== model_out()) begin
         failures++;
         $display("FAIL fullpp_model got=%h exp=%h", dut_out(), model_out());
      end
      bus.res_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (dut_out() !== model_out()) begin
            failures++;
            $display("FAIL fullpp_drain got=%h exp=%h", dut_out(), model_out());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(rand_ev(60, $urandom_range(0, 1) == 1));
         bus.res_ready = ($urandom_range(0, 99) < 55);
         tick();
         checks++;
         if (dut_out() !== model_out()) begin
            failures++;
            $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_out(), model_out());
         end
      end
      drive('0);
      bus.res_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
   endtask

   task automatic test_reset_midstream();
      bit seen = 0;
      bus.res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ev_t e = rand_ev(100, 0);
         e.v1 = 1'b1; e.f1[i] = 1'b1;
         drive(e);
         tick();
      end
      drive('0);
      tick();
      checks++;
      if (dut_out() !== model_out()) begin
         failures++;
         $display("FAIL midrst_before got=%h exp=%h", dut_out(), model_out());
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (dut_out() !== 22'd0) begin
         failures++;
         $display("FAIL midrst_outputs got=%h exp=%h", dut_out(), 22'd0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      clear_model();
      bus.res_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.res_valid === 1'b1) seen = 1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL midrst_stale got=%b exp=0", seen);
      end
`ifdef MATCH_PRIORITY_STATS_EN
      checks++;
      if ({stat_hit_cnt, stat_miss_cnt, stat_drop_cnt} !== 96'd0) begin
         failures++;
         $display("FAIL midrst_stats got=%0d/%0d/%0d exp=0/0/0", stat_hit_cnt, stat_miss_cnt, stat_drop_cnt);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_miss();
      test_full_drop();
      test_full_pop_push();
      test_random();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
